// File: rtl/guess_game_pkg.sv
// Shared types and constants for the number-guessing game core.
package guess_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT_GUESS,
    ST_JUDGE,
    ST_RESULT,
    ST_GAME_OVER
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b111_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  // Range of the drawn target per game mode; callers truncate to their width.
  function automatic logic [15:0] mode_mask(input logic [1:0] mode);
    case (mode)
      2'd0:    return 16'h0003;
      2'd1:    return 16'h0007;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Feedback taps of a maximal-length Fibonacci LFSR, shifting toward the MSB.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      2:       return 16'h0003;
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      default: return 16'hD008;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Hex nibble to active-low seven-segment pattern, ordered {a..g}.
module hex_to_sseg
  import guess_game_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'b000_0001;
      4'h1: seg = 7'b100_1111;
      4'h2: seg = 7'b001_0010;
      4'h3: seg = 7'b000_0110;
      4'h4: seg = 7'b100_1100;
      4'h5: seg = 7'b010_0100;
      4'h6: seg = 7'b010_0000;
      4'h7: seg = 7'b000_1111;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b000_0100;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b110_0000;
      4'hC: seg = 7'b011_0001;
      4'hD: seg = 7'b100_0010;
      4'hE: seg = 7'b011_0000;
      4'hF: seg = 7'b011_1000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/guess_game_core.sv
// Guessing game: LFSR target draw, judge/score FSM and 8-digit scanned display.
// state        | meaning
// IDLE         | waiting for first submit
// DRAW         | latch masked target and mode, clear tries
// WAIT_GUESS   | waiting for a guess submit
// JUDGE        | compare guess, update score
// RESULT       | hold playSound for RESULT_CYCLES
// GAME_OVER    | mode 3 out of tries, scores frozen until submit
module guess_game_core
  import guess_game_pkg::*;
#(
  parameter int GUESS_W       = 4,
  parameter int CNT_W         = 8,
  parameter int MAX_TRIES     = 3,
  parameter int RESULT_CYCLES = 50_000_000,
  parameter int SCAN_DIV      = 100_000,
  parameter logic [GUESS_W-1:0] SEED = GUESS_W'(1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         gameMode,
  input  logic [GUESS_W-1:0] userGuess,
  input  logic               ready,
  output logic [GUESS_W-1:0] randValue,
  output logic [CNT_W-1:0]   userCorrect,
  output logic [CNT_W-1:0]   userIncorrect,
  output logic               playSound,
  output logic               val,
  output logic [7:0]         AN,
  output logic [6:0]         C
);

  localparam int RES_W  = $clog2(RESULT_CYCLES + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam logic [GUESS_W-1:0] TAPS = GUESS_W'(lfsr_taps(GUESS_W));

  state_t             state;
  logic [GUESS_W-1:0] lfsr, masked, guess_q;
  logic [1:0]         mode_q;
  logic [TRY_W-1:0]   tries;
  logic [RES_W-1:0]   res_timer;
  logic [SCAN_W-1:0]  scan_timer;
  logic [2:0]         digit;
  logic               ready_q, submit, show_target, use_hex;
  logic [3:0]         nib;
  logic [6:0]         seg_hex;
  logic [7:0]         corr8, incorr8, rand8;

  assign masked = lfsr & GUESS_W'(mode_mask(gameMode));
  assign submit = ready & ~ready_q;

  // ready_q resets high so a button held through reset is not a submit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr    <= SEED;
      ready_q <= 1'b1;
    end else begin
      lfsr    <= {lfsr[GUESS_W-2:0], ^(lfsr & TAPS)};
      ready_q <= ready;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      randValue     <= '0;
      mode_q        <= '0;
      guess_q       <= '0;
      tries         <= '0;
      res_timer     <= '0;
      val           <= 1'b0;
      playSound     <= 1'b0;
      userCorrect   <= '0;
      userIncorrect <= '0;
    end else begin
      case (state)
        ST_IDLE: if (submit) state <= ST_DRAW;
        ST_DRAW: begin
          randValue <= masked;
          mode_q    <= gameMode;
          tries     <= '0;
          state     <= ST_WAIT_GUESS;
        end
        ST_WAIT_GUESS: if (submit) begin
          guess_q <= userGuess;
          state   <= ST_JUDGE;
        end
        ST_JUDGE: begin
          res_timer <= RES_W'(RESULT_CYCLES - 1);
          playSound <= 1'b1;
          state     <= ST_RESULT;
          if (guess_q == randValue) begin
            val <= 1'b1;
            if (userCorrect != '1) userCorrect <= userCorrect + 1'b1;
          end else begin
            val <= 1'b0;
            if (userIncorrect != '1) userIncorrect <= userIncorrect + 1'b1;
            if (tries != '1) tries <= tries + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_timer == '0) begin
            playSound <= 1'b0;
            if (val)
              state <= ST_DRAW;
            else if (mode_q == 2'd3 && tries == TRY_W'(MAX_TRIES))
              state <= ST_GAME_OVER;
            else
              state <= ST_WAIT_GUESS;
          end else begin
            res_timer <= res_timer - 1'b1;
          end
        end
        ST_GAME_OVER: if (submit) begin
          userCorrect   <= '0;
          userIncorrect <= '0;
          state         <= ST_DRAW;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_timer <= SCAN_W'(SCAN_DIV - 1);
      digit      <= '0;
    end else if (scan_timer == '0) begin
      scan_timer <= SCAN_W'(SCAN_DIV - 1);
      digit      <= digit + 3'd1;
    end else begin
      scan_timer <= scan_timer - 1'b1;
    end
  end

  assign AN          = ~(8'b1 << digit);
  assign show_target = (state == ST_RESULT && val) || state == ST_GAME_OVER;
  assign corr8       = 8'(userCorrect);
  assign incorr8     = 8'(userIncorrect);
  assign rand8       = 8'(randValue);

  always_comb begin
    nib     = 4'h0;
    use_hex = 1'b1;
    case (digit)
      3'd0: nib = corr8[3:0];
      3'd1: nib = corr8[7:4];
      3'd2: nib = incorr8[3:0];
      3'd3: nib = incorr8[7:4];
      3'd6: if (show_target) nib = rand8[3:0]; else use_hex = 1'b0;
      3'd7: if (show_target) nib = rand8[7:4]; else use_hex = 1'b0;
      default: use_hex = 1'b0;
    endcase
  end

  hex_to_sseg u_sseg (
    .hex (nib),
    .seg (seg_hex)
  );

  assign C = use_hex ? seg_hex : SEG_DASH;

endmodule

// File: tb/tb_guess_game_core.sv
// Directed bench for guess_game_core: scoring, timing, game over, display and saturation.
module tb_guess_game_core;

  logic       clock, reset;
  logic [1:0] gameMode;
  logic [3:0] userGuess;
  logic       ready;
  logic [3:0] randValue;
  logic [7:0] userCorrect, userIncorrect;
  logic       playSound, val;
  logic [7:0] AN;
  logic [6:0] C;

  logic [1:0] s_mode;
  logic [3:0] s_guess, s_rand;
  logic       s_ready, s_play, s_val;
  logic [1:0] s_correct, s_incorrect;
  logic [7:0] s_an;
  logic [6:0] s_c;

  int vectors = 0;
  int miscompares = 0;

  guess_game_core #(.GUESS_W(4), .CNT_W(8), .MAX_TRIES(3), .RESULT_CYCLES(10),
                    .SCAN_DIV(1), .SEED(4'd1)) dut (
    .clock(clock), .reset(reset), .gameMode(gameMode), .userGuess(userGuess),
    .ready(ready), .randValue(randValue), .userCorrect(userCorrect),
    .userIncorrect(userIncorrect), .playSound(playSound), .val(val), .AN(AN), .C(C)
  );

  guess_game_core #(.GUESS_W(4), .CNT_W(2), .MAX_TRIES(3), .RESULT_CYCLES(10),
                    .SCAN_DIV(1), .SEED(4'd1)) dut_sat (
    .clock(clock), .reset(reset), .gameMode(s_mode), .userGuess(s_guess),
    .ready(s_ready), .randValue(s_rand), .userCorrect(s_correct),
    .userIncorrect(s_incorrect), .playSound(s_play), .val(s_val), .AN(s_an), .C(s_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input logic [3:0] n);
    logic [6:0] hi;
    case (n)
      4'h0: hi = 7'b1111110; 4'h1: hi = 7'b0110000; 4'h2: hi = 7'b1101101;
      4'h3: hi = 7'b1111001; 4'h4: hi = 7'b0110011; 4'h5: hi = 7'b1011011;
      4'h6: hi = 7'b1011111; 4'h7: hi = 7'b1110000; 4'h8: hi = 7'b1111111;
      4'h9: hi = 7'b1111011; 4'hA: hi = 7'b1110111; 4'hB: hi = 7'b0011111;
      4'hC: hi = 7'b1001110; 4'hD: hi = 7'b0111101; 4'hE: hi = 7'b1001111;
      default: hi = 7'b1000111;
    endcase
    return ~hi;
  endfunction

  // Walks all eight digits (SCAN_DIV=1) and checks each pattern.
  task automatic check_display(input logic show, input logic [7:0] corr,
                               input logic [7:0] incorr, input logic [7:0] target);
    logic [6:0] exp;
    int idx;
    for (int i = 0; i < 8; i++) begin
      idx = 0;
      for (int d = 0; d < 8; d++) if (AN[d] == 1'b0) idx = d;
      chk("an_one_hot_low", $countones(~AN), 1);
      case (idx)
        0: exp = seg_exp(corr[3:0]);
        1: exp = seg_exp(corr[7:4]);
        2: exp = seg_exp(incorr[3:0]);
        3: exp = seg_exp(incorr[7:4]);
        6: exp = show ? seg_exp(target[3:0]) : 7'b1111110;
        7: exp = show ? seg_exp(target[7:4]) : 7'b1111110;
        default: exp = 7'b1111110;
      endcase
      chk($sformatf("digit%0d_seg", idx), C, exp);
      @(negedge clock);
    end
  endtask

  task automatic submit();
    @(negedge clock) ready = 1'b1;
    @(negedge clock) ready = 1'b0;
  endtask

  task automatic submit_s();
    @(negedge clock) s_ready = 1'b1;
    @(negedge clock) s_ready = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while (playSound === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("result_exit_bound", (n < 200), 1);
  endtask

  task automatic wait_quiet_s();
    int n = 0;
    while (s_play === 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("sat_result_exit_bound", (n < 200), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; ready = 1'b1; gameMode = 2'd2; userGuess = 4'h0;
    s_ready = 1'b0; s_mode = 2'd2; s_guess = 4'h0;
    @(negedge clock);
    chk("rst_an", AN, 8'hFE);
    chk("rst_correct", userCorrect, 0);
    chk("rst_incorrect", userIncorrect, 0);
    chk("rst_play", playSound, 0);
    chk("rst_val", val, 0);
    chk("rst_rand", randValue, 0);
    reset = 1'b0;

    // Button held through reset must not start a round.
    repeat (5) @(negedge clock);
    ready = 1'b0;
    submit();
    @(negedge clock);
    repeat (2) @(negedge clock);
    chk("held_ready_no_judge", userCorrect + userIncorrect, 0);

    // Correct guess: two-clock latency and playSound length.
    userGuess = randValue;
    submit();
    chk("judge_lat_1clk", userCorrect, 0);
    @(negedge clock);
    chk("correct_cnt", userCorrect, 1);
    chk("correct_val", val, 1);
    gameMode = 2'd0;
    n = 0;
    while (playSound === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("play_len", n, 10);
    @(negedge clock);
    chk("mode0_range", (randValue <= 4'd3), 1);

    // Wrong guess in mode 0, digits 6-7 dashed.
    userGuess = 4'hF;
    submit();
    @(negedge clock);
    chk("wrong_incorrect", userIncorrect, 1);
    chk("wrong_val", val, 0);
    chk("wrong_play", playSound, 1);
    check_display(1'b0, 8'd1, 8'd1, 8'd0);
    wait_quiet();

    // Mode change mid-round ignored: latched mode 0 never ends the game.
    gameMode = 2'd3;
    for (int k = 0; k < 2; k++) begin
      userGuess = randValue ^ 4'h1;
      submit();
      @(negedge clock);
      chk("mid_mode_wrong", userIncorrect, 2 + k);
      wait_quiet();
    end
    userGuess = randValue;
    submit();
    @(negedge clock);
    chk("mid_mode_no_gameover", userCorrect, 2);
    wait_quiet();
    @(negedge clock);

    // Mode 3: three wrong guesses lead to GAME_OVER.
    for (int k = 0; k < 3; k++) begin
      userGuess = randValue ^ 4'h1;
      submit();
      @(negedge clock);
      chk("m3_wrong", userIncorrect, 4 + k);
      wait_quiet();
    end
    check_display(1'b1, 8'd2, 8'd6, {4'h0, randValue});
    chk("go_frozen_correct", userCorrect, 2);
    chk("go_frozen_incorrect", userIncorrect, 6);
    submit();
    chk("go_clear_correct", userCorrect, 0);
    chk("go_clear_incorrect", userIncorrect, 0);
    @(negedge clock);
    check_display(1'b0, 8'd0, 8'd0, 8'd0);

    // Level-held ready judges once; pulses during RESULT are dropped.
    userGuess = randValue;
    @(negedge clock) ready = 1'b1;
    repeat (100) @(negedge clock);
    ready = 1'b0;
    chk("held_one_judge_c", userCorrect, 1);
    chk("held_one_judge_i", userIncorrect, 0);
    userGuess = randValue ^ 4'h1;
    submit();
    @(negedge clock);
    @(negedge clock) ready = 1'b1;
    @(negedge clock) ready = 1'b0;
    @(negedge clock) ready = 1'b1;
    @(negedge clock) ready = 1'b0;
    wait_quiet();
    repeat (3) @(negedge clock);
    chk("result_pulse_i", userIncorrect, 1);
    chk("result_pulse_c", userCorrect, 1);

    // Asynchronous reset during RESULT.
    userGuess = randValue;
    submit();
    @(negedge clock);
    chk("pre_rst_play", playSound, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_play", playSound, 0);
    chk("async_an", AN, 8'hFE);
    chk("async_correct", userCorrect, 0);
    chk("async_val", val, 0);
    chk("async_seg", C, seg_exp(4'h0));
    @(negedge clock) reset = 1'b0;

    // CNT_W=2 instance: five correct rounds saturate at 3.
    submit_s();
    @(negedge clock);
    for (int r = 0; r < 5; r++) begin
      s_guess = s_rand;
      submit_s();
      @(negedge clock);
      chk("sat_correct", s_correct, (r < 3) ? r + 1 : 3);
      wait_quiet_s();
      @(negedge clock);
    end
    chk("sat_incorrect", s_incorrect, 0);
    chk("sat_val", s_val, 1);
    chk("sat_an", $countones(~s_an), 1);
    chk("sat_seg_known", (^s_c !== 1'bx), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
